// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: FSM state encoding, frame geometry
// and FIFO entry width ({err, data[7:0]}).
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STOP  = 2'd2
  } ps2_state_t;

  localparam int DATA_BITS  = 8;   // payload bits per frame
  localparam int SHIFT_BITS = 9;   // payload plus odd-parity bit
  localparam int ENTRY_W    = 9;   // stored entry: {err, data}

endpackage

// File: rtl/ps2_scan_fifo.sv
// First-word-fall-through scan-code FIFO. The head entry is presented
// combinationally from the read pointer; a pop and a push on the same edge
// both succeed even when full, so a full FIFO that is being drained never
// drops the incoming entry.
module ps2_scan_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_AW = 3
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               i_push,
  input  logic [ENTRY_W-1:0] i_wdata,
  input  logic               i_pop,
  output logic               o_dav,
  output logic [ENTRY_W-1:0] o_rdata,
  output logic [FIFO_AW:0]   o_count,
  output logic               o_drop
);

  localparam int DEPTH = 2 ** FIFO_AW;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_count == (FIFO_AW+1)'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & ~w_empty;
  // A simultaneous pop frees the slot the push needs.
  assign w_do_push = i_push & (~w_full | w_do_pop);

  assign o_drop  = i_push & w_full & ~w_do_pop;
  assign o_dav   = ~w_empty;
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Entry storage; cleared on reset so the head reads zero afterwards.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 receive controller: digital clock filter, frame deserialiser with
// odd-parity / stop-bit checking, inter-edge watchdog, and a scan-code FIFO
// with sticky overflow.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int FIFO_AW        = 3,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             PS2_Clk,
  input  logic             PS2_Data,
  input  logic             DoRead,
  input  logic             Clr_Ovf,
  output logic             Scan_DAV,
  output logic [7:0]       Scan_Code,
  output logic             Scan_Err,
  output logic [FIFO_AW:0] Fifo_Count,
  output logic             Overflow,
  output logic             Frame_Abort
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  // Synchroniser and filter state
  logic                  r_data_meta;
  logic                  r_datr;
  logic [FILTER_LEN-1:0] r_clk_shift;
  logic                  r_clk_f;
  logic                  r_fall;

  // Receive FSM state
  ps2_state_t            r_state,   w_state_next;
  logic [SHIFT_BITS-1:0] r_shift,   w_shift_next;
  logic [3:0]            r_bit_cnt, w_bit_cnt_next;
  logic                  r_parity,  w_parity_next;
  logic [WD_W-1:0]       r_wdog,    w_wdog_next;
  logic                  r_abort,   w_abort_next;

  logic                  w_push;
  logic                  w_push_err;
  logic [ENTRY_W-1:0]    w_push_data;
  logic [ENTRY_W-1:0]    w_head;
  logic                  w_drop;
  logic                  r_overflow;

  // Two-flop synchroniser for the data line.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_data_meta <= 1'b0;
      r_datr      <= 1'b0;
    end else begin
      r_data_meta <= PS2_Data;
      r_datr      <= r_data_meta;
    end
  end

  // Clock filter: level changes only after FILTER_LEN equal samples; a
  // high-to-low change of the filtered level emits a one-cycle fall pulse.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_clk_shift <= '0;
      r_clk_f     <= 1'b0;
      r_fall      <= 1'b0;
    end else begin
      r_clk_shift <= {r_clk_shift[FILTER_LEN-2:0], PS2_Clk};
      r_fall      <= 1'b0;
      if (&r_clk_shift) begin
        r_clk_f <= 1'b1;
      end else if (~|r_clk_shift) begin
        r_clk_f <= 1'b0;
        r_fall  <= r_clk_f;
      end
    end
  end

  // Receive FSM and watchdog state registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_parity  <= 1'b0;
      r_wdog    <= '0;
      r_abort   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_parity  <= w_parity_next;
      r_wdog    <= w_wdog_next;
      r_abort   <= w_abort_next;
    end
  end

  // Next-state logic: frame progress advances only on fall pulses; between
  // pulses inside a frame the watchdog counts towards an abort.
  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_cnt_next = r_bit_cnt;
    w_parity_next  = r_parity;
    w_wdog_next    = r_wdog;
    w_abort_next   = 1'b0;
    w_push         = 1'b0;
    // Accumulated parity over data+parity must be 1 and stop must be 1.
    w_push_err     = ~r_parity | ~r_datr;
    case (r_state)
      IDLE: begin
        if (r_fall && !r_datr) begin
          w_state_next   = SHIFT;
          w_bit_cnt_next = '0;
          w_parity_next  = 1'b0;
          w_wdog_next    = '0;
        end
      end
      SHIFT: begin
        if (r_fall) begin
          w_shift_next   = {r_datr, r_shift[SHIFT_BITS-1:1]};
          w_parity_next  = r_parity ^ r_datr;
          w_bit_cnt_next = r_bit_cnt + 1'b1;
          w_wdog_next    = '0;
          if (r_bit_cnt == 4'(SHIFT_BITS - 1)) begin
            w_state_next = STOP;
          end
        end else if (r_wdog == WD_LAST) begin
          w_state_next = IDLE;
          w_abort_next = 1'b1;
        end else begin
          w_wdog_next = r_wdog + 1'b1;
        end
      end
      STOP: begin
        if (r_fall) begin
          w_push       = 1'b1;
          w_state_next = IDLE;
          w_wdog_next  = '0;
        end else if (r_wdog == WD_LAST) begin
          w_state_next = IDLE;
          w_abort_next = 1'b1;
        end else begin
          w_wdog_next = r_wdog + 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_push_data = {w_push_err, r_shift[DATA_BITS-1:0]};

  ps2_scan_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_push  (w_push),
    .i_wdata (w_push_data),
    .i_pop   (DoRead),
    .o_dav   (Scan_DAV),
    .o_rdata (w_head),
    .o_count (Fifo_Count),
    .o_drop  (w_drop)
  );

  // Sticky overflow; a drop on the same edge as a clear keeps it set.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (Clr_Ovf) begin
      r_overflow <= 1'b0;
    end
  end

  assign Scan_Code   = w_head[DATA_BITS-1:0];
  assign Scan_Err    = w_head[ENTRY_W-1];
  assign Overflow    = r_overflow;
  assign Frame_Abort = r_abort;

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised PS/2 receive controller for keyboards, mice and similar devices. It filters the PS/2 clock digitally and deserialises 11-bit frames (start, 8 data LSB first, odd parity, stop). Each received byte and its error flag are pushed into an on-chip first-word-fall-through FIFO, so the host can fall behind by several scan codes without losing any. It adds a frame-timeout watchdog and sticky overflow reporting, and sits between the PS/2 pins and the keyboard decoder / CPU port.

Parameters:
FILTER_LEN, 8, number of consecutive equal PS2_Clk samples needed to change the filtered clock (2..16)
FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW entries
TIMEOUT_CYCLES, 65536, Clk cycles allowed between falling edges inside a frame before the frame is aborted (must be > FILTER_LEN + 2)

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
PS2_Clk  in  1  raw PS/2 clock line (asynchronous)
PS2_Data  in  1  raw PS/2 data line (asynchronous)
DoRead  in  1  pop the head entry; ignored when Scan_DAV=0
Clr_Ovf  in  1  clears Overflow
Scan_DAV  out  1  FIFO not empty
Scan_Code  out  8  head entry data (valid when Scan_DAV=1)
Scan_Err  out  1  head entry error flag (parity wrong or stop bit 0)
Fifo_Count  out  FIFO_AW+1  number of stored entries
Overflow  out  1  sticky: a completed frame was dropped because the FIFO was full
Frame_Abort  out  1  one-cycle pulse when the watchdog aborts a frame

Behaviour:
- Reset: one clock, Clk; asynchronous, active-high Reset. All registers clear. Outputs: Scan_DAV=0, Scan_Code=0, Scan_Err=0, Fifo_Count=0, Overflow=0, Frame_Abort=0. Filtered clock resets to 0 and the state machine to IDLE. Reset asserted mid-frame discards the partial frame and all FIFO contents.
- Data sync: PS2_Data passes through a 2-flop synchroniser (Datr).
- Clock filter: FILTER_LEN-bit shift register of PS2_Clk.
  - All ones: clk_f<=1.
  - All zeros: clk_f<=0; if clk_f was 1, assert fall (1-cycle pulse).
  - Glitches shorter than FILTER_LEN cycles produce no pulse.
- Receive FSM, evaluated only on fall pulses:
  - IDLE: if Datr=0, go to SHIFT with bit_cnt=0, parity=0, watchdog=0. If Datr=1 (false start), stay in IDLE.
  - SHIFT: shift Datr into a 9-bit register (right shift, LSB first), parity^=Datr, bit_cnt++. After the 9th bit (8 data + parity), go to STOP.
  - STOP: on a fall pulse, err = ~parity | ~Datr, where parity is the XOR of data and parity bits and must be 1. Push {err, data}. Go to IDLE.
- Watchdog: in SHIFT/STOP, a counter increments each Clk cycle and resets on every fall pulse. When it reaches TIMEOUT_CYCLES-1: go to IDLE, no push, Frame_Abort=1 for one cycle, Overflow unaffected.
- FIFO behaviour:
  - The push is written on the same Clk edge that samples the stop bit. Scan_DAV, Scan_Code, Scan_Err and Fifo_Count reflect it from the next cycle.
  - Outputs show the head entry combinationally from the memory/read pointer. Pop happens on the Clk edge where DoRead=1 and Scan_DAV=1.
  - Push while full: entry is dropped and Overflow<=1.
  - Push and pop on the same edge while full: both succeed; count is unchanged; no overflow.
  - Push and pop on the same edge with count 1: count stays 1 and the head becomes the new entry.
  - DoRead while empty: ignored; count never underflows.
  - Pointers wrap modulo 2**FIFO_AW. Count saturates at 2**FIFO_AW.
- Overflow is cleared by Clr_Ovf. If Clr_Ovf and an overflowing push occur on the same edge, the set wins.
- When Scan_DAV=0, Scan_Code and Scan_Err hold the last read-pointer contents; this is don't-care.

Decomposition:
- Package ps2_pkg: FSM state encoding (IDLE, SHIFT, STOP), frame constants (DATA_BITS=8, SHIFT_BITS=9) and the FIFO entry width constant ENTRY_W=9.
- Sub-module ps2_scan_fifo: parametrised synchronous FIFO on FIFO_AW with first-word-fall-through, count and full/empty. The filter and FSM stay in the top module.

Test Plan:
- Frame 0x1C with parity bit 0 and stop 1 -> one entry: Scan_Code=0x1C, Scan_Err=0, Fifo_Count=1. DoRead for 1 cycle -> Fifo_Count=0, Scan_DAV=0.
- Frame 0x1C with parity bit 1 -> Scan_Code=0x1C, Scan_Err=1. A following frame 0xF0 with parity bit 1 and stop 1 -> Scan_Err=0 for that entry.
- 3-cycle low glitch on idle PS2_Clk with FILTER_LEN=8 -> no fall pulse, FSM stays in IDLE, Fifo_Count stays 0.
- FIFO_AW=3: 9 frames 0x01..0x09 with no reads -> Fifo_Count=8, Overflow=1. The pops return 0x01..0x08. Clr_Ovf -> Overflow=0.
- Start bit + 4 data bits, then the clock stops for TIMEOUT_CYCLES (set to 64 in the bench) -> Frame_Abort pulses once, no entry is pushed. A following full frame 0x5A is received correctly.
- FIFO full, then a frame completes on the same edge as DoRead -> Fifo_Count stays 8, Overflow=0, and the last pop-out order is preserved.
